// File: rtl/zx81_tape_player_if.sv
// Tape RAM read port: the player drives the address and the RAM returns data.
// The data is valid two clk_sys cycles after the address changes.
interface zx81_tape_player_if;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/zx81_tape_player.sv
// Replays a .p image from tape RAM as a ZX81 pulse-coded EAR stream at real tape speed.
// Latency: leader of LEADER_TICKS ce ticks, then 3 clk_sys cycles per byte fetch. No backpressure; stop aborts.
module zx81_tape_player #(
    parameter int         PULSE_TICKS  = 488,
    parameter int         GAP_TICKS    = 4225,
    parameter int         LEADER_TICKS = 3250000,
    parameter logic [7:0] NAME_BYTE    = 8'hA6
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      add_name,
    input  logic [13:0]               tape_size,
    zx81_tape_player_if.master        ram,
    output logic                      tape_out,
    output logic                      busy,
    output logic                      done,
    output logic [13:0]               byte_pos
);

    typedef enum logic [3:0] {
        IDLE, LEADER, FETCH, WAIT1, WAIT2, PULSE_HI, PULSE_LO, GAP, TRAILER
    } state_t;

    localparam logic [21:0] PULSE_LD  = 22'(PULSE_TICKS - 1);
    localparam logic [21:0] GAP_LD    = 22'(GAP_TICKS - 1);
    localparam logic [21:0] LEADER_LD = 22'(LEADER_TICKS - 1);

    state_t      state;
    logic [21:0] tick_cnt;
    logic [3:0]  pulse_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [13:0] size_q;
    logic        name_pending;
    logic        is_name;

    // Pulse counter holds the remaining pulses minus one for the current bit.
    function automatic logic [3:0] pulses_for(input logic b);
        return b ? 4'd8 : 4'd3;
    endfunction

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            pulse_cnt    <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            size_q       <= '0;
            name_pending <= 1'b0;
            is_name      <= 1'b0;
            ram.rd_addr  <= '0;
            tape_out     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            byte_pos     <= '0;
        end else begin
            done <= 1'b0;
            if (stop && state != IDLE) begin
                state    <= IDLE;
                tape_out <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            if (tape_size == 14'd0) begin
                                done <= 1'b1;
                            end else begin
                                size_q       <= tape_size;
                                name_pending <= add_name;
                                byte_pos     <= '0;
                                busy         <= 1'b1;
                                tick_cnt     <= LEADER_LD;
                                state        <= LEADER;
                            end
                        end
                    end
                    LEADER, TRAILER: begin
                        if (ce) begin
                            if (tick_cnt == 22'd0) begin
                                tick_cnt <= '0;
                                if (state == LEADER) begin
                                    state <= FETCH;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                tick_cnt <= tick_cnt - 22'd1;
                            end
                        end
                    end
                    FETCH: begin
                        bit_cnt <= 3'd7;
                        if (name_pending) begin
                            name_pending <= 1'b0;
                            is_name      <= 1'b1;
                            shreg        <= NAME_BYTE;
                            pulse_cnt    <= pulses_for(NAME_BYTE[7]);
                            tick_cnt     <= PULSE_LD;
                            tape_out     <= 1'b1;
                            state        <= PULSE_HI;
                        end else begin
                            is_name     <= 1'b0;
                            ram.rd_addr <= byte_pos;
                            state       <= WAIT1;
                        end
                    end
                    WAIT1: state <= WAIT2;
                    WAIT2: begin
                        shreg     <= ram.rd_data;
                        pulse_cnt <= pulses_for(ram.rd_data[7]);
                        tick_cnt  <= PULSE_LD;
                        tape_out  <= 1'b1;
                        state     <= PULSE_HI;
                    end
                    PULSE_HI: begin
                        if (ce) begin
                            if (tick_cnt == 22'd0) begin
                                tape_out <= 1'b0;
                                tick_cnt <= PULSE_LD;
                                state    <= PULSE_LO;
                            end else begin
                                tick_cnt <= tick_cnt - 22'd1;
                            end
                        end
                    end
                    PULSE_LO: begin
                        if (ce) begin
                            if (tick_cnt != 22'd0) begin
                                tick_cnt <= tick_cnt - 22'd1;
                            end else if (pulse_cnt == 4'd0) begin
                                tick_cnt <= GAP_LD;
                                state    <= GAP;
                            end else begin
                                pulse_cnt <= pulse_cnt - 4'd1;
                                tick_cnt  <= PULSE_LD;
                                tape_out  <= 1'b1;
                                state     <= PULSE_HI;
                            end
                        end
                    end
                    GAP: begin
                        if (ce) begin
                            if (tick_cnt != 22'd0) begin
                                tick_cnt <= tick_cnt - 22'd1;
                            end else if (bit_cnt != 3'd0) begin
                                bit_cnt   <= bit_cnt - 3'd1;
                                shreg     <= {shreg[6:0], 1'b0};
                                pulse_cnt <= pulses_for(shreg[6]);
                                tick_cnt  <= PULSE_LD;
                                tape_out  <= 1'b1;
                                state     <= PULSE_HI;
                            end else if (is_name) begin
                                tick_cnt <= '0;
                                state    <= FETCH;
                            end else begin
                                // The name byte does not occupy a position in the image.
                                byte_pos <= byte_pos + 14'd1;
                                if (byte_pos + 14'd1 == size_q) begin
                                    tick_cnt <= LEADER_LD;
                                    state    <= TRAILER;
                                end else begin
                                    tick_cnt <= '0;
                                    state    <= FETCH;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zx81_tape_player.sv
// Directed bench for zx81_tape_player: decodes the EAR stream in ce ticks and compares to hand-derived bytes.
module tb_zx81_tape_player;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        add_name = 1'b0;
    logic [13:0] tape_size = '0;
    logic        tape_out;
    logic        busy;
    logic        done;
    logic [13:0] byte_pos;

    zx81_tape_player_if ram_if ();

    zx81_tape_player #(
        .PULSE_TICKS (2),
        .GAP_TICKS   (5),
        .LEADER_TICKS(10),
        .NAME_BYTE   (8'hA6)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce       (ce),
        .start    (start),
        .stop     (stop),
        .add_name (add_name),
        .tape_size(tape_size),
        .ram      (ram_if.master),
        .tape_out (tape_out),
        .busy     (busy),
        .done     (done),
        .byte_pos (byte_pos)
    );

    always #5 clk_sys = ~clk_sys;

    int ce_div = 0;
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            ce_div = (ce_div + 1) % 4;
            ce = (ce_div == 0);
        end
    end

    // Bench RAM returns inverted data in the first cycle after an address change.
    logic [7:0]  mem [0:15];
    logic [13:0] seen_addr = '0;
    logic [13:0] ok_addr = '0;
    assign ram_if.rd_data = (ram_if.rd_addr == ok_addr) ? mem[ram_if.rd_addr[3:0]]
                                                        : ~mem[ram_if.rd_addr[3:0]];
    initial begin
        forever begin
            @(negedge clk_sys);
            ok_addr   = seen_addr;
            seen_addr = ram_if.rd_addr;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int          lows[$];
    int          highs[$];
    int          run_ce;
    logic        prev_to;
    int          lead_ce, tail_ce, done_cnt;
    logic [13:0] addr_log[$];
    logic [13:0] last_addr;
    logic [7:0]  got_bytes[$];
    logic [7:0]  exp_bytes[$];
    int          shape_err;
    int          k;

    task automatic clear_mon();
        lows.delete();
        highs.delete();
        addr_log.delete();
        run_ce    = 0;
        prev_to   = tape_out;
        lead_ce   = 0;
        tail_ce   = 0;
        done_cnt  = 0;
        last_addr = ram_if.rd_addr;
    endtask

    // Segment lengths are measured in ce ticks, so fetch cycles between bytes do not matter.
    task automatic step();
        @(negedge clk_sys);
        if (tape_out !== prev_to) begin
            if (tape_out) begin
                lows.push_back(run_ce);
                tail_ce = 0;
            end else begin
                highs.push_back(run_ce);
            end
            run_ce = 0;
        end
        prev_to = tape_out;
        if (ce) run_ce++;
        if (ce && busy && !tape_out) begin
            if (lows.size() == 0) lead_ce++;
            else tail_ce++;
        end
        if (done) done_cnt++;
        if (ram_if.rd_addr != last_addr) begin
            addr_log.push_back(ram_if.rd_addr);
            last_addr = ram_if.rd_addr;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic play(input string tag);
        int n;
        n = 0;
        while (!(done_cnt > 0 && !busy) && n < 20000) begin
            step();
            n++;
        end
        chk({tag, "_finished"}, 32'(n < 20000), 1);
    endtask

    task automatic decode();
        int         bits[$];
        int         cnt;
        logic [7:0] b;
        got_bytes.delete();
        shape_err = 0;
        cnt = 0;
        b = '0;
        if (highs.size() != lows.size()) shape_err++;
        for (int i = 0; i < lows.size(); i++) begin
            if (i > 0 && lows[i] == 7) begin
                bits.push_back(cnt);
                cnt = 0;
            end else if (i > 0 && lows[i] != 2) begin
                shape_err++;
            end
            cnt++;
        end
        if (lows.size() > 0) bits.push_back(cnt);
        for (int i = 0; i < highs.size(); i++)
            if (highs[i] != 2) shape_err++;
        if (bits.size() % 8 != 0) shape_err++;
        for (int i = 0; i < bits.size(); i++) begin
            if (bits[i] != 9 && bits[i] != 4) shape_err++;
            b = {b[6:0], (bits[i] == 9)};
            if (i % 8 == 7) got_bytes.push_back(b);
        end
    endtask

    task automatic check_play(input string tag, input logic [13:0] exp_pos);
        decode();
        chk({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i),
                (i < got_bytes.size()) ? 32'(got_bytes[i]) : 32'hDEAD, 32'(exp_bytes[i]));
        chk({tag, "_shape"}, shape_err, 0);
        chk({tag, "_leader_ticks"}, lead_ce, 10);
        chk({tag, "_trailer_ticks"}, tail_ce, 17);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_byte_pos"}, byte_pos, exp_pos);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        clear_mon();
        repeat (3) step();
        chk("reset_outputs", {tape_out, busy, done, byte_pos, ram_if.rd_addr}, 0);
        reset = 1'b0;
        step();

        // Single byte 80: one 9-pulse bit then seven 4-pulse bits.
        mem[0] = 8'h80; tape_size = 14'd1; add_name = 1'b0;
        clear_mon();
        do_start();
        chk("t1_busy_after_start", busy, 1);
        chk("t1_leader_low", tape_out, 0);
        play("t1");
        exp_bytes = '{8'h80};
        check_play("t1", 14'd1);

        // Empty image: immediate done, no playback.
        tape_size = 14'd0;
        clear_mon();
        do_start();
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        chk("t2_tape_out", tape_out, 0);
        step();
        chk("t2_done_single", done, 0);

        // start and stop together while idle: stop wins.
        tape_size = 14'd1;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("t2b_busy_start_stop", busy, 0);
        step();
        chk("t2b_busy_later", {busy, tape_out}, 0);

        // Name byte then three data bytes; also a stray start mid-play.
        mem[0] = 8'h01; mem[1] = 8'hFF; mem[2] = 8'h00;
        tape_size = 14'd3; add_name = 1'b1;
        clear_mon();
        do_start();
        add_name = 1'b0;
        repeat (60) step();
        do_start();
        play("t3");
        exp_bytes = '{8'hA6, 8'h01, 8'hFF, 8'h00};
        check_play("t3", 14'd3);
        chk("t3_addr_count", addr_log.size(), 2);
        chk("t3_addr1", (addr_log.size() > 0) ? 32'(addr_log[0]) : 32'hDEAD, 1);
        chk("t3_addr2", (addr_log.size() > 1) ? 32'(addr_log[1]) : 32'hDEAD, 2);
        chk("t3_rd_addr_end", ram_if.rd_addr, 2);

        // Stop during the third high pulse, then replay from byte 0.
        mem[0] = 8'h80; tape_size = 14'd1;
        clear_mon();
        do_start();
        k = 0;
        while (!(lows.size() == 3 && tape_out) && k < 5000) begin step(); k++; end
        chk("t4_reach_pulse3", 32'(k < 5000), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_stop_outputs", {tape_out, busy}, 0);
        repeat (20) step();
        chk("t4_no_done", done_cnt, 0);
        clear_mon();
        do_start();
        play("t4r");
        exp_bytes = '{8'h80};
        check_play("t4r", 14'd1);

        // Reset in the gap after the first bit, then a clean replay.
        clear_mon();
        do_start();
        k = 0;
        while (!(lows.size() == 9 && !tape_out && run_ce == 4) && k < 5000) begin step(); k++; end
        chk("t5_reach_gap", 32'(k < 5000), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_reset_outputs", {tape_out, busy, done, byte_pos, ram_if.rd_addr}, 0);
        step();
        clear_mon();
        do_start();
        play("t5r");
        exp_bytes = '{8'h80};
        check_play("t5r", 14'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
